// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared definitions for the integer ALU reservation station.
//   - ROB_SZ_LOG / TAG_W_DEF : ROB tag sizing (tag = ROB index plus one spare bit)
//   - RS_SZ_DEF              : default number of reservation-station entries
//   - OPT_* / OP_*           : ALU optype / opcode encodings carried through unchanged
// No ports; imported by alu_rs and its testbench.
package alu_rs_pkg;

    localparam int ROB_SZ_LOG = 4;
    localparam int TAG_W_DEF  = ROB_SZ_LOG + 1;
    localparam int RS_SZ_DEF  = 8;

    // Instruction classes handled by the ALU.
    localparam logic [3:0] OPT_CAL  = 4'd0;
    localparam logic [3:0] OPT_CALI = 4'd1;
    localparam logic [3:0] OPT_BRA  = 4'd2;
    localparam logic [3:0] OPT_JUM  = 4'd3;

    // ALU operations within a class.
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_LUI   = 4'd5;
    localparam logic [3:0] OP_AUIPC = 4'd6;

endpackage

// File: rtl/rs_prio_enc.sv
// rs_prio_enc: lowest-index priority encoder.
//   req_i   [N]     request vector
//   found_o         at least one request bit set
//   idx_o   [IDX_W] index of the lowest set bit (0 when none)
module rs_prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scanning from the top down lets the lowest set bit overwrite last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the combinational integer ALU.
// Holds up to RS_SZ instructions, snoops two CDBs to resolve operand tags and
// issues the lowest-index ready entry each cycle through registered outputs.
//   clk_in, rst_n_in (async, active-low), rdy_in (global stall), clear_in (flush)
//   in_*            dispatch interface (in_flg = valid); full = no free entry
//   cdb0_* / cdb1_* result buses (cdb0 = ALU, cdb1 = load/store), cdb0 has priority
//   run_flg, rd_fr, Vj, Vk, imm, pc, opcode, optype : registered ALU issue port
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SZ = RS_SZ_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             clear_in,
    input  logic             in_flg,
    input  logic             in_qj_busy,
    input  logic             in_qk_busy,
    input  logic [TAG_W-1:0] in_qj,
    input  logic [TAG_W-1:0] in_qk,
    input  logic [31:0]      in_vj,
    input  logic [31:0]      in_vk,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_pc,
    input  logic [3:0]       in_opcode,
    input  logic [3:0]       in_optype,
    input  logic [TAG_W-1:0] in_rd,
    output logic             full,
    input  logic             cdb0_flg,
    input  logic [TAG_W-1:0] cdb0_tag,
    input  logic [31:0]      cdb0_val,
    input  logic             cdb1_flg,
    input  logic [TAG_W-1:0] cdb1_tag,
    input  logic [31:0]      cdb1_val,
    output logic             run_flg,
    output logic [TAG_W-1:0] rd_fr,
    output logic [31:0]      Vj,
    output logic [31:0]      Vk,
    output logic [31:0]      imm,
    output logic [31:0]      pc,
    output logic [3:0]       opcode,
    output logic [3:0]       optype
);

    localparam int IDX_W = $clog2(RS_SZ);

    // Entry state: control bits are reset, payload is not.
    logic [RS_SZ-1:0] valid_q, valid_d;
    logic [RS_SZ-1:0] qj_busy_q, qk_busy_q;
    logic [TAG_W-1:0] qj_q [RS_SZ];
    logic [TAG_W-1:0] qk_q [RS_SZ];
    logic [TAG_W-1:0] rd_q [RS_SZ];
    logic [31:0]      vj_q [RS_SZ];
    logic [31:0]      vk_q [RS_SZ];
    logic [31:0]      imm_q [RS_SZ];
    logic [31:0]      pc_q [RS_SZ];
    logic [3:0]       opcode_q [RS_SZ];
    logic [3:0]       optype_q [RS_SZ];

    // Issue port registers.
    logic             run_flg_q;
    logic [TAG_W-1:0] rd_fr_q;
    logic [31:0]      vj_out_q, vk_out_q, imm_out_q, pc_out_q;
    logic [3:0]       opcode_out_q, optype_out_q;

    logic             free_found, rdy_found;
    logic [IDX_W-1:0] free_idx, rdy_idx;
    logic [RS_SZ-1:0] ready_w;
    logic             advance, disp_go;
    logic [32:0]      disp_j_d, disp_k_d;

    // Returns {busy, value} after snooping both CDBs; cdb0 wins a double match.
    function automatic logic [32:0] snoop(input logic busy, input logic [TAG_W-1:0] tag,
                                          input logic [31:0] val);
        if (busy && cdb0_flg && (cdb0_tag == tag)) return {1'b0, cdb0_val};
        if (busy && cdb1_flg && (cdb1_tag == tag)) return {1'b0, cdb1_val};
        return {busy, val};
    endfunction

    // Readiness uses registered busy bits only: a wake-up this edge issues next cycle.
    assign ready_w = valid_q & ~qj_busy_q & ~qk_busy_q;
    assign full    = &valid_q;
    assign advance = rdy_in & ~clear_in;
    assign disp_go = advance & in_flg & free_found;

    assign disp_j_d = snoop(in_qj_busy, in_qj, in_vj);
    assign disp_k_d = snoop(in_qk_busy, in_qk, in_vk);

    rs_prio_enc #(.N(RS_SZ), .IDX_W(IDX_W)) u_free_enc (
        .req_i   (~valid_q),
        .found_o (free_found),
        .idx_o   (free_idx)
    );

    rs_prio_enc #(.N(RS_SZ), .IDX_W(IDX_W)) u_rdy_enc (
        .req_i   (ready_w),
        .found_o (rdy_found),
        .idx_o   (rdy_idx)
    );

    // The issued entry is always valid and the dispatch slot always invalid,
    // so the two updates never touch the same bit.
    always_comb begin
        valid_d = valid_q;
        if (rdy_found)
            valid_d[rdy_idx] = 1'b0;
        if (in_flg && free_found)
            valid_d[free_idx] = 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q      <= '0;
            run_flg_q    <= 1'b0;
            rd_fr_q      <= '0;
            vj_out_q     <= '0;
            vk_out_q     <= '0;
            imm_out_q    <= '0;
            pc_out_q     <= '0;
            opcode_out_q <= '0;
            optype_out_q <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                valid_q   <= '0;
                run_flg_q <= 1'b0;
            end else begin
                valid_q   <= valid_d;
                run_flg_q <= rdy_found;
                if (rdy_found) begin
                    rd_fr_q      <= rd_q[rdy_idx];
                    vj_out_q     <= vj_q[rdy_idx];
                    vk_out_q     <= vk_q[rdy_idx];
                    imm_out_q    <= imm_q[rdy_idx];
                    pc_out_q     <= pc_q[rdy_idx];
                    opcode_out_q <= opcode_q[rdy_idx];
                    optype_out_q <= optype_q[rdy_idx];
                end
            end
        end
    end

    // Payload: CDB wake-up of waiting entries plus the dispatch write.
    always_ff @(posedge clk_in) begin
        if (advance) begin
            for (int i = 0; i < RS_SZ; i++) begin
                if (valid_q[i]) begin
                    {qj_busy_q[i], vj_q[i]} <= snoop(qj_busy_q[i], qj_q[i], vj_q[i]);
                    {qk_busy_q[i], vk_q[i]} <= snoop(qk_busy_q[i], qk_q[i], vk_q[i]);
                end
            end
            if (disp_go) begin
                {qj_busy_q[free_idx], vj_q[free_idx]} <= disp_j_d;
                {qk_busy_q[free_idx], vk_q[free_idx]} <= disp_k_d;
                qj_q[free_idx]     <= in_qj;
                qk_q[free_idx]     <= in_qk;
                rd_q[free_idx]     <= in_rd;
                imm_q[free_idx]    <= in_imm;
                pc_q[free_idx]     <= in_pc;
                opcode_q[free_idx] <= in_opcode;
                optype_q[free_idx] <= in_optype;
            end
        end
    end

    assign run_flg = run_flg_q;
    assign rd_fr   = rd_fr_q;
    assign Vj      = vj_out_q;
    assign Vk      = vk_out_q;
    assign imm     = imm_out_q;
    assign pc      = pc_out_q;
    assign opcode  = opcode_out_q;
    assign optype  = optype_out_q;

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: scoreboard bench for alu_rs. A slot-level reference model predicts
// each issue and queues it; a negedge monitor pops and compares whenever the
// DUT presents a fresh issue, and checks full every cycle.
module tb_alu_rs;
    import alu_rs_pkg::*;

    localparam int RS = RS_SZ_DEF;
    localparam int TW = TAG_W_DEF;

    logic          clk_in   = 1'b0;
    logic          rst_n_in = 1'b1;
    logic          rdy_in   = 1'b1;
    logic          clear_in = 1'b0;
    logic          in_flg   = 1'b0;
    logic          in_qj_busy = 1'b0, in_qk_busy = 1'b0;
    logic [TW-1:0] in_qj = '0, in_qk = '0, in_rd = '0;
    logic [31:0]   in_vj = '0, in_vk = '0, in_imm = '0, in_pc = '0;
    logic [3:0]    in_opcode = '0, in_optype = '0;
    logic          cdb0_flg = 1'b0, cdb1_flg = 1'b0;
    logic [TW-1:0] cdb0_tag = '0, cdb1_tag = '0;
    logic [31:0]   cdb0_val = '0, cdb1_val = '0;
    logic          full, run_flg;
    logic [TW-1:0] rd_fr;
    logic [31:0]   Vj, Vk, imm, pc;
    logic [3:0]    opcode, optype;

    always #5 clk_in = ~clk_in;

    alu_rs #(.RS_SZ(RS), .TAG_W(TW)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .in_flg(in_flg), .in_qj_busy(in_qj_busy), .in_qk_busy(in_qk_busy),
        .in_qj(in_qj), .in_qk(in_qk), .in_vj(in_vj), .in_vk(in_vk),
        .in_imm(in_imm), .in_pc(in_pc), .in_opcode(in_opcode), .in_optype(in_optype),
        .in_rd(in_rd), .full(full),
        .cdb0_flg(cdb0_flg), .cdb0_tag(cdb0_tag), .cdb0_val(cdb0_val),
        .cdb1_flg(cdb1_flg), .cdb1_tag(cdb1_tag), .cdb1_val(cdb1_val),
        .run_flg(run_flg), .rd_fr(rd_fr), .Vj(Vj), .Vk(Vk), .imm(imm), .pc(pc),
        .opcode(opcode), .optype(optype)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit          v, jb, kb;
        logic [TW-1:0] qj, qk, rd;
        logic [31:0] vj, vk, imm, pc;
        logic [3:0]  opc, opt;
    } ent_t;

    typedef logic [TW+136-1:0] iss_t;   // {rd, Vj, Vk, imm, pc, opcode, optype}

    ent_t m[RS];
    iss_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic bit m_full();
        for (int i = 0; i < RS; i++)
            if (!m[i].v) return 1'b0;
        return 1'b1;
    endfunction

    // Operand resolution rule: a pending operand takes the value of a matching
    // bus, cdb0 before cdb1; otherwise it stays as it was.
    function automatic logic [32:0] resolve(bit busy, logic [TW-1:0] tag, logic [31:0] val);
        if (!busy) return {1'b0, val};
        if (cdb0_flg && cdb0_tag == tag) return {1'b0, cdb0_val};
        if (cdb1_flg && cdb1_tag == tag) return {1'b0, cdb1_val};
        return {1'b1, val};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS; i++) m[i].v = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        int iss, fr;
        bit was_full;
        logic [32:0] r;
        iss = -1;
        fr  = -1;
        if (!rst_n_in) begin
            model_reset();
            return;
        end
        if (!rdy_in) return;
        if (clear_in) begin
            for (int i = 0; i < RS; i++) m[i].v = 1'b0;
            return;
        end
        was_full = m_full();
        for (int i = 0; i < RS; i++)
            if (iss < 0 && m[i].v && !m[i].jb && !m[i].kb) iss = i;
        for (int i = 0; i < RS; i++)
            if (fr < 0 && !m[i].v) fr = i;
        for (int i = 0; i < RS; i++) begin
            if (m[i].v) begin
                r = resolve(m[i].jb, m[i].qj, m[i].vj);
                m[i].jb = r[32]; m[i].vj = r[31:0];
                r = resolve(m[i].kb, m[i].qk, m[i].vk);
                m[i].kb = r[32]; m[i].vk = r[31:0];
            end
        end
        if (iss >= 0) begin
            exp_q.push_back({m[iss].rd, m[iss].vj, m[iss].vk, m[iss].imm, m[iss].pc,
                             m[iss].opc, m[iss].opt});
            m[iss].v = 1'b0;
        end
        if (in_flg && !was_full) begin
            m[fr].v = 1'b1;
            r = resolve(in_qj_busy, in_qj, in_vj);
            m[fr].jb = r[32]; m[fr].vj = r[31:0];
            r = resolve(in_qk_busy, in_qk, in_vk);
            m[fr].kb = r[32]; m[fr].vk = r[31:0];
            m[fr].qj = in_qj; m[fr].qk = in_qk; m[fr].rd = in_rd;
            m[fr].imm = in_imm; m[fr].pc = in_pc;
            m[fr].opc = in_opcode; m[fr].opt = in_optype;
        end
    endtask

    // ---------------- monitor ----------------
    bit   mon_en      = 1'b0;
    bit   rdy_at_edge = 1'b0;
    bit   pres, expp;
    iss_t got, want;

    always @(posedge clk_in) rdy_at_edge <= rdy_in;

    always @(negedge clk_in) begin
        if (mon_en) begin
            // A held run_flg during a stall is not a new issue.
            pres = run_flg && rdy_at_edge;
            expp = (exp_q.size() > 0);
            n_chk++;
            if (pres != expp) begin
                n_fail++;
                $display("FAIL issue_present t=%0t: got %0b required %0b", $time, pres, expp);
            end
            if (expp) want = exp_q.pop_front();
            if (pres && expp) begin
                got = {rd_fr, Vj, Vk, imm, pc, opcode, optype};
                n_chk++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL issue_data t=%0t: got %h required %h", $time, got, want);
                end
            end
            n_chk++;
            if (full !== m_full()) begin
                n_fail++;
                $display("FAIL full t=%0t: got %0b required %0b", $time, full, m_full());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(string nm, logic [63:0] g, logic [63:0] w);
        n_chk++;
        if (g !== w) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %0h required %0h", nm, $time, g, w);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
        in_flg   = 1'b0;
        cdb0_flg = 1'b0;
        cdb1_flg = 1'b0;
        clear_in = 1'b0;
    endtask

    task automatic disp(bit jb, logic [TW-1:0] qj, logic [31:0] vj,
                        bit kb, logic [TW-1:0] qk, logic [31:0] vk,
                        logic [TW-1:0] rd, logic [3:0] opt);
        in_flg = 1'b1;
        in_qj_busy = jb; in_qj = qj; in_vj = vj;
        in_qk_busy = kb; in_qk = qk; in_vk = vk;
        in_rd = rd; in_optype = opt;
        in_opcode = 4'($urandom_range(0, 15));
        in_imm = $urandom;
        in_pc  = $urandom;
    endtask

    task automatic cdb0(logic [TW-1:0] t, logic [31:0] v);
        cdb0_flg = 1'b1; cdb0_tag = t; cdb0_val = v;
    endtask

    task automatic cdb1(logic [TW-1:0] t, logic [31:0] v);
        cdb1_flg = 1'b1; cdb1_tag = t; cdb1_val = v;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // Power-on reset.
        #2 rst_n_in = 1'b0;
        model_reset();
        #1;
        chk("rst_run_flg", run_flg, 0);
        chk("rst_full", full, 0);
        chk("rst_rd_fr", rd_fr, 0);
        chk("rst_vj", Vj, 0);
        chk("rst_vk", Vk, 0);
        chk("rst_imm", imm, 0);
        chk("rst_pc", pc, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_optype", optype, 0);
        mon_en = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;

        // Ready ADD: issue visible after the second edge, for one cycle.
        disp(0, 0, 5, 0, 0, 7, 3, OPT_CAL);
        in_opcode = OP_ADD;
        cyc();
        chk("add_no_early_issue", run_flg, 0);
        cyc();
        chk("add_run_flg", run_flg, 1);
        chk("add_rd_fr", rd_fr, 3);
        chk("add_vj", Vj, 5);
        chk("add_vk", Vk, 7);
        chk("add_optype", optype, OPT_CAL);
        chk("add_opcode", opcode, OP_ADD);
        cyc();
        chk("add_run_drop", run_flg, 0);

        // Dependency resolved by cdb1; a non-matching tag does nothing.
        disp(1, 6, 0, 0, 0, 1, 4, OPT_CAL);
        cyc();
        cyc();
        cdb1(5, 32'h55);
        cyc();
        cdb1(6, 32'h100);
        cyc();
        chk("dep_not_before_wake", run_flg, 0);
        cyc();
        chk("dep_run_flg", run_flg, 1);
        chk("dep_vj", Vj, 32'h100);
        chk("dep_rd_fr", rd_fr, 4);
        cyc();

        // Dispatch-cycle forwarding, single and double bus match.
        disp(0, 0, 3, 1, 2, 0, 7, OPT_BRA);
        cdb0(2, 9);
        cyc();
        cyc();
        chk("fwd_vk", Vk, 9);
        disp(0, 0, 3, 1, 2, 0, 8, OPT_BRA);
        cdb0(2, 9);
        cdb1(2, 4);
        cyc();
        cyc();
        chk("fwd_both_vk", Vk, 9);
        chk("fwd_both_rd", rd_fr, 8);
        cyc();

        // Fill all entries with waiting instructions, then wake 5 and 2 together.
        for (int i = 0; i < RS; i++) begin
            disp(1, TW'(16 + i), 0, 0, 0, 32'(i), TW'(i), OPT_CALI);
            cyc();
        end
        chk("fill_full", full, 1);
        disp(0, 0, 1, 0, 0, 1, 30, OPT_CAL);   // ignored while full
        cyc();
        chk("fill_still_full", full, 1);
        cdb0(18, 32'hA2);
        cdb1(21, 32'hA5);
        cyc();
        chk("wake_full_held", full, 1);
        cyc();
        chk("order_first_rd", rd_fr, 2);
        chk("order_first_vj", Vj, 32'hA2);
        chk("order_full_freed", full, 0);
        cyc();
        chk("order_second_rd", rd_fr, 5);
        chk("order_second_vj", Vj, 32'hA5);
        for (int i = 0; i < RS; i++) begin
            if (i != 2 && i != 5) begin
                cdb0(TW'(16 + i), 32'(i * 3));
                cyc();
            end
        end
        repeat (3) cyc();

        // Flush with waiting and ready entries.
        disp(1, 24, 0, 0, 0, 0, 1, OPT_CAL); cyc();
        disp(1, 25, 0, 0, 0, 0, 2, OPT_CAL); cyc();
        disp(0, 0, 1, 0, 0, 1, 12, OPT_CAL); cyc();
        disp(0, 0, 1, 0, 0, 1, 13, OPT_CAL);
        clear_in = 1'b1;
        cyc();
        chk("clr_run_flg", run_flg, 0);
        chk("clr_full", full, 0);
        cdb0(24, 1); cyc();
        cdb0(25, 1); cyc();
        repeat (3) cyc();

        // Stall during a broadcast: outputs hold, the broadcast is lost.
        disp(1, 7, 0, 0, 0, 2, 10, OPT_CAL); cyc();
        disp(0, 0, 11, 0, 0, 22, 9, OPT_JUM); cyc();
        cyc();
        chk("stall_pre_run", run_flg, 1);
        rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cdb0(7, 32'h77);
            cyc();
            chk("stall_run_hold", run_flg, 1);
            chk("stall_rd_hold", rd_fr, 9);
            chk("stall_vj_hold", Vj, 11);
            chk("stall_vk_hold", Vk, 22);
        end
        rdy_in = 1'b1;
        repeat (2) cyc();
        cdb0(7, 32'h88);
        cyc();
        cyc();
        chk("stall_late_vj", Vj, 32'h88);
        chk("stall_late_rd", rd_fr, 10);
        cyc();

        // Randomized traffic.
        repeat (1500) begin
            rdy_in   = ($urandom_range(0, 7) != 0);
            clear_in = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 1) == 1 && !m_full())
                disp(1'($urandom_range(0, 1)), TW'($urandom_range(0, 7)), $urandom,
                     1'($urandom_range(0, 1)), TW'($urandom_range(0, 7)), $urandom,
                     TW'($urandom_range(0, 31)), 4'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) cdb0(TW'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 2) == 0) cdb1(TW'($urandom_range(0, 7)), $urandom);
            cyc();
        end
        rdy_in = 1'b1;
        clear_in = 1'b1;
        cyc();

        // Asynchronous reset with entries loaded and an issue in flight.
        disp(1, 26, 0, 0, 0, 0, 1, OPT_CAL); cyc();
        disp(1, 27, 0, 0, 0, 0, 2, OPT_CAL); cyc();
        disp(0, 0, 4, 0, 0, 4, 14, OPT_CAL); cyc();
        disp(1, 28, 0, 0, 0, 0, 3, OPT_CAL); cyc();
        chk("mid_pre_run", run_flg, 1);
        chk("mid_pre_rd", rd_fr, 14);
        #2 rst_n_in = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_run_flg", run_flg, 0);
        chk("mid_rst_full", full, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        cdb0(26, 1); cdb1(27, 2); cyc();
        cdb0(28, 3); cyc();
        repeat (4) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
